ddr3_rw_arbiter: RTL

Sequences the DDR3 controller user interface between the acquisition write stream (drained from the DDR3 write FIFO) and readout burst requests. Accepts one 128-bit burst per command. Issues MIG read/write commands with bounded write streaks, flow-controlled reads and an outstanding-read limit. Returns read data toward the readout FIFO. Sits between the write FIFO / readout sequencer and the DDR3 memory controller in the ddr3_domain_clk domain.

---
 rtl/ddr3_arb_pkg.sv | 26 ++
 rtl/ddr3_rw_arbiter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/ddr3_arb_pkg.sv
// ---------------------------------------------------------------------------
// ddr3_arb_pkg
// Shared definitions for the DDR3 read/write arbiter:
//   - arb_state_t       : arbiter FSM states
//   - APP_CMD_WR/RD     : MIG app_cmd encodings
//   - burst_to_app_addr : burst index -> MIG byte-lane address mapping
// ---------------------------------------------------------------------------
package ddr3_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2
    } arb_state_t;

    localparam logic [2:0] APP_CMD_WR = 3'b000;
    localparam logic [2:0] APP_CMD_RD = 3'b001;

    // One burst is 8 beats of the MIG column address, so the burst index
    // sits above three zero bits. Returned wide; callers cast down to their
    // own app_addr width, which also zero-extends short burst indices.
    function automatic logic [63:0] burst_to_app_addr(input logic [31:0] burst);
        return {29'd0, burst, 3'b000};
    endfunction

endpackage

// File: rtl/ddr3_rw_arbiter.sv
// ---------------------------------------------------------------------------
// ddr3_rw_arbiter
// Shares the MIG user interface between the acquisition write stream and
// readout burst jobs. One command per cycle at most; writes have priority
// but a pending read gets a slot after every WR_STREAK_MAX writes. Reads are
// throttled by the readout FIFO almost-full flag and by a cap on read
// commands still waiting for their data.
//
// Ports
//   ddr3_domain_clk / ddr3_domain_reset : clock, synchronous active-high reset
//   wr_req_valid/addr/dat, wr_req_ready : write FIFO head and pop strobe
//   rd_start_addr, rd_burst_cnt         : read job parameters
//   enable_reading                      : rising edge starts a read job
//   rd_fifo_almost_full                 : stops new read commands
//   reading_done, rd_busy               : read job status
//   app_*                               : MIG user interface
//   rd_dat, rd_dat_valid                : read data, registered once
// ---------------------------------------------------------------------------
module ddr3_rw_arbiter
    import ddr3_arb_pkg::*;
#(
    parameter int ADDR_W          = 23,
    parameter int APP_ADDR_W      = 27,
    parameter int CNT_W           = 24,
    parameter int MAX_OUTSTANDING = 16,
    parameter int WR_STREAK_MAX   = 8
) (
    input  logic                  ddr3_domain_clk,
    input  logic                  ddr3_domain_reset,
    input  logic                  wr_req_valid,
    input  logic [ADDR_W-1:0]     wr_req_addr,
    input  logic [127:0]          wr_req_dat,
    output logic                  wr_req_ready,
    input  logic [ADDR_W-1:0]     rd_start_addr,
    input  logic [CNT_W-1:0]      rd_burst_cnt,
    input  logic                  enable_reading,
    input  logic                  rd_fifo_almost_full,
    output logic                  reading_done,
    output logic                  rd_busy,
    input  logic                  app_rdy,
    input  logic                  app_wdf_rdy,
    output logic                  app_en,
    output logic [2:0]            app_cmd,
    output logic [APP_ADDR_W-1:0] app_addr,
    output logic [127:0]          app_wdf_data,
    output logic                  app_wdf_wren,
    output logic                  app_wdf_end,
    input  logic                  app_rd_data_valid,
    input  logic [127:0]          app_rd_data,
    output logic [127:0]          rd_dat,
    output logic                  rd_dat_valid
);

    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int SW = $clog2(WR_STREAK_MAX + 1);

    arb_state_t        state_reg, state_next;
    logic [ADDR_W-1:0] ptr_reg;
    logic [CNT_W-1:0]  remain_reg;
    logic [OW-1:0]     outst_reg, outst_next;
    logic [SW-1:0]     streak_reg, streak_inc;
    logic              rd_busy_reg, done_reg, en_d_reg, rd_dat_valid_reg;

    logic wr_elig, rd_elig, wr_acc, rd_acc, rd_ret, streak_done, rd_start;

    assign wr_elig = wr_req_valid;
    assign rd_elig = rd_busy_reg && (remain_reg != '0) && !rd_fifo_almost_full
                     && (outst_reg < OW'(MAX_OUTSTANDING));

    assign wr_acc = (state_reg == ST_WRITE) && wr_req_valid && app_rdy && app_wdf_rdy;
    assign rd_acc = (state_reg == ST_READ) && rd_elig && app_rdy;

    // A data return with nothing outstanding is a stray beat; drop it so
    // the counter cannot wrap.
    assign rd_ret = app_rd_data_valid && (outst_reg != '0);
    assign outst_next = outst_reg + OW'(rd_acc) - OW'(rd_ret);

    // Streak saturates so a long write run with no eligible read still hands
    // over on the first write after a read becomes eligible.
    assign streak_inc  = (streak_reg == SW'(WR_STREAK_MAX)) ? streak_reg
                                                           : streak_reg + SW'(1);
    assign streak_done = (streak_inc == SW'(WR_STREAK_MAX));

    assign rd_start = enable_reading && !en_d_reg && !rd_busy_reg;

    // Next state and MIG command outputs
    always_comb begin
        state_next   = state_reg;
        app_en       = 1'b0;
        app_cmd      = APP_CMD_WR;
        app_addr     = '0;
        app_wdf_data = '0;
        app_wdf_wren = 1'b0;
        app_wdf_end  = 1'b0;
        wr_req_ready = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (wr_elig)      state_next = ST_WRITE;
                else if (rd_elig) state_next = ST_READ;
            end
            ST_WRITE: begin
                app_cmd      = APP_CMD_WR;
                app_addr     = APP_ADDR_W'(burst_to_app_addr(32'(wr_req_addr)));
                app_wdf_data = wr_req_dat;
                if (wr_req_valid) begin
                    app_en       = 1'b1;
                    app_wdf_wren = 1'b1;
                    app_wdf_end  = 1'b1;
                end
                wr_req_ready = wr_acc;
                if (wr_acc && rd_elig && streak_done) state_next = ST_READ;
                else if (!wr_elig)                    state_next = ST_IDLE;
            end
            ST_READ: begin
                app_cmd  = APP_CMD_RD;
                app_addr = APP_ADDR_W'(burst_to_app_addr(32'(ptr_reg)));
                app_en   = rd_elig;
                // A command waiting on app_rdy is held; once it is taken a
                // waiting write gets the next slot.
                if (!rd_elig)              state_next = wr_elig ? ST_WRITE : ST_IDLE;
                else if (rd_acc && wr_elig) state_next = ST_WRITE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State, streak, outstanding count and read-job bookkeeping
    always_ff @(posedge ddr3_domain_clk) begin
        if (ddr3_domain_reset) begin
            state_reg   <= ST_IDLE;
            streak_reg  <= '0;
            outst_reg   <= '0;
            ptr_reg     <= '0;
            remain_reg  <= '0;
            rd_busy_reg <= 1'b0;
            done_reg    <= 1'b0;
            en_d_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            en_d_reg  <= enable_reading;
            outst_reg <= outst_next;

            if (state_next == ST_WRITE && state_reg != ST_WRITE) streak_reg <= '0;
            else if (wr_acc)                                     streak_reg <= streak_inc;

            if (rd_start) begin
                ptr_reg    <= rd_start_addr;
                remain_reg <= rd_burst_cnt;
                // An empty job has nothing to wait for: report done at once.
                if (rd_burst_cnt == '0) begin
                    done_reg <= 1'b1;
                end else begin
                    rd_busy_reg <= 1'b1;
                    done_reg    <= 1'b0;
                end
            end else begin
                if (rd_acc) begin
                    ptr_reg    <= ptr_reg + ADDR_W'(1);
                    remain_reg <= remain_reg - CNT_W'(1);
                end
                if (rd_busy_reg && remain_reg == '0 && outst_reg == '0) begin
                    rd_busy_reg <= 1'b0;
                    done_reg    <= 1'b1;
                end else if (!enable_reading) begin
                    done_reg <= 1'b0;
                end
            end
        end
    end

    assign rd_busy      = rd_busy_reg;
    assign reading_done = done_reg;

    // Read return path, one register stage, independent of the FSM
    always_ff @(posedge ddr3_domain_clk) begin
        if (ddr3_domain_reset) rd_dat_valid_reg <= 1'b0;
        else                   rd_dat_valid_reg <= app_rd_data_valid;
    end
    assign rd_dat_valid = rd_dat_valid_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_rd_lane
            logic [31:0] lane_reg;
            always_ff @(posedge ddr3_domain_clk) begin
                if (ddr3_domain_reset) lane_reg <= '0;
                else                   lane_reg <= app_rd_data[gi*32 +: 32];
            end
            assign rd_dat[gi*32 +: 32] = lane_reg;
        end
    endgenerate

endmodule
